// File: rtl/hub75_pkg.sv
// hub75_capture shared types and default geometry.
// Pixel word layout and drain FSM states.
package hub75_pkg;

  localparam int WIDTH_D   = 96;
  localparam int HEIGHT_D  = 48;
  localparam int CHAINED_D = 1;
  localparam int BPC_D     = 4;

  localparam int NROW = HEIGHT_D / 2;
  localparam int NCOL = WIDTH_D * CHAINED_D;
  localparam int CW   = $clog2(NCOL);
  localparam int PW   = $clog2(BPC_D);

  typedef logic [5:0] rgb6_t;

  typedef struct packed {
    logic [4:0]    row;
    logic [CW-1:0] col;
    logic [PW-1:0] plane;
    logic [2:0]    rgb0;
    logic [2:0]    rgb1;
  } pix_word_t;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } st_e;

endpackage

// File: rtl/hub75_edge_sync.sv
// HUB75 input register stage.
// Rise detect for sclk/lat on the registered copies.
module hub75_edge_sync
  import hub75_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       lat,
  input  logic       oe,
  input  logic [4:0] row_in,
  input  rgb6_t      rgb_in,
  output logic       sclk_rise,
  output logic       lat_rise,
  output logic       oe_s,
  output logic [4:0] row_s,
  output rgb6_t      rgb_s
);

  logic       sclk_q, sclk_d;
  logic       sclk_p_q, sclk_p_d;
  logic       lat_q, lat_d;
  logic       lat_p_q, lat_p_d;
  logic       oe_q, oe_d;
  logic [4:0] row_q, row_d;
  rgb6_t      rgb_q, rgb_d;

  // next values: sample pins, keep previous registered strobe copies
  always_comb begin
    sclk_d   = sclk;
    sclk_p_d = sclk_q;
    lat_d    = lat;
    lat_p_d  = lat_q;
    oe_d     = oe;
    row_d    = row_in;
    rgb_d    = rgb_in;
  end

  // register stage; oe resets inactive so idle reset time is not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q   <= 1'b0;
      sclk_p_q <= 1'b0;
      lat_q    <= 1'b0;
      lat_p_q  <= 1'b0;
      oe_q     <= 1'b1;
      row_q    <= '0;
      rgb_q    <= '0;
    end else begin
      sclk_q   <= sclk_d;
      sclk_p_q <= sclk_p_d;
      lat_q    <= lat_d;
      lat_p_q  <= lat_p_d;
      oe_q     <= oe_d;
      row_q    <= row_d;
      rgb_q    <= rgb_d;
    end
  end

  assign sclk_rise = sclk_q & ~sclk_p_q;
  assign lat_rise  = lat_q & ~lat_p_q;
  assign oe_s      = oe_q;
  assign row_s     = row_q;
  assign rgb_s     = rgb_q;

endmodule

// File: rtl/hub75_capture.sv
// HUB75 receive-side capture: shift, latch to hold buffer,
// then stream the row out as per-pixel words.
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int WIDTH   = WIDTH_D,
  parameter int HEIGHT  = HEIGHT_D,
  parameter int CHAINED = CHAINED_D,
  parameter int BPC     = BPC_D
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  sclk,
  input  logic                                  lat,
  input  logic                                  oe,
  input  logic                                  a,
  input  logic                                  b,
  input  logic                                  c,
  input  logic                                  d,
  input  logic                                  e,
  input  logic                                  r0,
  input  logic                                  g0,
  input  logic                                  b0,
  input  logic                                  r1,
  input  logic                                  g1,
  input  logic                                  b1,
  output logic                                  pix_valid,
  input  logic                                  pix_ready,
  output logic [4:0]                            pix_row,
  output logic [$clog2(WIDTH*CHAINED)-1:0]      pix_col,
  output logic [$clog2(BPC)-1:0]                pix_plane,
  output logic [2:0]                            pix_rgb0,
  output logic [2:0]                            pix_rgb1,
  output logic                                  frame_done,
  output logic [15:0]                           on_cycles,
  output logic                                  overrun,
  output logic                                  len_err,
  input  logic                                  clr_err
);

  localparam int NC  = WIDTH * CHAINED;
  localparam int NR  = HEIGHT / 2;
  localparam int CWL = $clog2(NC);
  localparam int PWL = $clog2(BPC);
  localparam int SW  = $clog2(NC + 1);

  logic       sclk_rise, lat_rise, oe_s;
  logic [4:0] row_s;
  rgb6_t      rgb_s;

  hub75_edge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .lat       (lat),
    .oe        (oe),
    .row_in    ({a, b, c, d, e}),
    .rgb_in    ({r0, g0, b0, r1, g1, b1}),
    .sclk_rise (sclk_rise),
    .lat_rise  (lat_rise),
    .oe_s      (oe_s),
    .row_s     (row_s),
    .rgb_s     (rgb_s)
  );

  st_e            state_q, state_d;
  logic [SW-1:0]  scnt_q, scnt_d;
  rgb6_t          sbuf_q [NC];
  rgb6_t          sbuf_d [NC];
  rgb6_t          hold_q [NC];
  rgb6_t          hold_d [NC];
  logic [4:0]     row_q, row_d;
  logic [PWL-1:0] plane_q, plane_d;
  logic [CWL-1:0] col_q, col_d;
  logic [15:0]    oecnt_q, oecnt_d;
  logic [15:0]    on_q, on_d;
  logic           ovr_q, ovr_d;
  logic           len_q, len_d;
  logic           len_set, ovr_set, fd;
  rgb6_t          cur;

  // shift, latch transfer, drain FSM and OE counter
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    sbuf_d  = sbuf_q;
    hold_d  = hold_q;
    row_d   = row_q;
    plane_d = plane_q;
    col_d   = col_q;
    oecnt_d = oecnt_q;
    on_d    = on_q;
    len_set = 1'b0;
    ovr_set = 1'b0;
    fd      = 1'b0;
    if (sclk_rise && scnt_q < SW'(NC)) begin
      sbuf_d[scnt_q[CWL-1:0]] = rgb_s;
      scnt_d = scnt_q + 1'b1;
    end
    if (!oe_s && oecnt_q != 16'hffff) begin
      oecnt_d = oecnt_q + 16'd1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (lat_rise) begin
          hold_d  = sbuf_d;
          row_d   = row_s;
          if (row_s == row_q) begin
            plane_d = (plane_q == PWL'(BPC - 1)) ? '0 : plane_q + 1'b1;
          end else begin
            plane_d = '0;
          end
          len_set = (scnt_d != SW'(NC));
          col_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        ovr_set = lat_rise;
        if (pix_ready) begin
          if (col_q == CWL'(NC - 1)) begin
            col_d   = '0;
            state_d = ST_IDLE;
            fd      = (row_q == 5'(NR - 1)) &&
                      (plane_q == PWL'(BPC - 1));
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
    endcase
    if (lat_rise) begin
      scnt_d  = '0;
      on_d    = oecnt_q;
      oecnt_d = '0;
    end
    len_d = (len_q & ~clr_err) | len_set;
    ovr_d = (ovr_q & ~clr_err) | ovr_set;
  end

  // state and counters; reset aborts any stream in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      row_q   <= '0;
      plane_q <= '0;
      col_q   <= '0;
      oecnt_q <= '0;
      on_q    <= '0;
      ovr_q   <= 1'b0;
      len_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      col_q   <= col_d;
      oecnt_q <= oecnt_d;
      on_q    <= on_d;
      ovr_q   <= ovr_d;
      len_q   <= len_d;
    end
  end

  // pixel storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    sbuf_q <= sbuf_d;
    hold_q <= hold_d;
  end

  assign cur        = hold_q[col_q];
  assign pix_valid  = (state_q == ST_DRAIN);
  assign pix_row    = row_q;
  assign pix_col    = col_q;
  assign pix_plane  = plane_q;
  assign pix_rgb0   = pix_valid ? cur[5:3] : 3'b000;
  assign pix_rgb1   = pix_valid ? cur[2:0] : 3'b000;
  assign frame_done = fd;
  assign on_cycles  = on_q;
  assign overrun    = ovr_q;
  assign len_err    = len_q;

endmodule

// File: tb/tb_hub75_capture.sv
// hub75_capture bench: panel-level driver plus a row model
// that predicts every emitted pixel word and the flags.
module tb_hub75_capture;
  import hub75_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 0, lat = 0, oe = 1;
  logic a = 0, b = 0, c = 0, d = 0, e = 0;
  logic r0 = 0, g0 = 0, b0 = 0, r1 = 0, g1 = 0, b1 = 0;
  logic pix_valid, pix_ready = 1'b1;
  logic [4:0] pix_row;
  logic [CW-1:0] pix_col;
  logic [PW-1:0] pix_plane;
  logic [2:0] pix_rgb0, pix_rgb1;
  logic frame_done;
  logic [15:0] on_cycles;
  logic overrun, len_err;
  logic clr_err = 1'b0;

  hub75_capture dut (
    .clk(clk), .rst(rst), .sclk(sclk), .lat(lat), .oe(oe),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_row(pix_row), .pix_col(pix_col),
    .pix_plane(pix_plane), .pix_rgb0(pix_rgb0),
    .pix_rgb1(pix_rgb1), .frame_done(frame_done),
    .on_cycles(on_cycles), .overrun(overrun),
    .len_err(len_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    pix_word_t w;
    logic      fd;
  } exp_t;

  int n_vec = 0;
  int n_bad = 0;

  exp_t      q[$];
  logic [5:0] sh [NCOL];
  int        npulse = 0;
  logic [4:0] prev_row = 0;
  int        plane = 0;
  int        oe_acc = 0;
  int        exp_on = 0;
  bit        exp_len = 0;
  bit        exp_ovr = 0;
  int        fd_exp = 0;
  int        fd_seen = 0;
  bit        stalled = 0;
  pix_word_t prev_w;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sclk_pulse(input logic [5:0] v);
    {r0, g0, b0, r1, g1, b1} = v;
    repeat (3) tick();
    sclk = 1'b1;
    repeat (3) tick();
    sclk = 1'b0;
    if (npulse < NCOL) begin
      sh[npulse] = v;
      npulse++;
    end
  endtask

  // mode 0: rgb0 = col[2:0], rgb1 random; mode 1: all random
  task automatic shift_row(input int n, input int mode);
    logic [2:0] kc;
    for (int k = 0; k < n; k++) begin
      kc = 3'(k);
      if (mode == 0) sclk_pulse({kc, 3'($urandom)});
      else sclk_pulse(6'($urandom));
    end
  endtask

  task automatic do_latch(input logic [4:0] r);
    exp_t x;
    if (q.size() == 0) begin
      plane = (r == prev_row) ? (plane + 1) % BPC_D : 0;
      prev_row = r;
      if (npulse != NCOL) exp_len = 1;
      for (int k = 0; k < NCOL; k++) begin
        x.w.row   = r;
        x.w.col   = CW'(k);
        x.w.plane = PW'(plane);
        x.w.rgb0  = sh[k][5:3];
        x.w.rgb1  = sh[k][2:0];
        x.fd = (r == 5'(NROW - 1)) && (plane == BPC_D - 1) &&
               (k == NCOL - 1);
        if (x.fd) fd_exp++;
        q.push_back(x);
      end
    end else begin
      exp_ovr = 1;
    end
    npulse = 0;
    exp_on = oe_acc;
    oe_acc = 0;
    {a, b, c, d, e} = r;
    tick();
    lat = 1'b1;
    repeat (2) tick();
    lat = 1'b0;
    tick();
  endtask

  task automatic oe_low(input int n);
    if (n > 0) begin
      oe = 1'b0;
      repeat (n) tick();
      oe = 1'b1;
      oe_acc = (oe_acc + n > 65535) ? 65535 : oe_acc + n;
    end
  endtask

  task automatic wait_drain(input bit bp);
    int t = 0;
    while (q.size() != 0 && t < 3000) begin
      pix_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      t++;
    end
    pix_ready = 1'b1;
    check("drain_left", 32'(q.size()), 0);
    repeat (3) tick();
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_len"}, 32'(len_err), 32'(exp_len));
    check({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    check({tag, "_on"}, 32'(on_cycles), 32'(exp_on));
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    exp_len = 0;
    exp_ovr = 0;
    tick();
  endtask

  // output monitor, sampled on the falling edge
  initial begin
    pix_word_t cw;
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
      end else begin
        cw = '{row: pix_row, col: pix_col, plane: pix_plane,
               rgb0: pix_rgb0, rgb1: pix_rgb1};
        if (frame_done) fd_seen++;
        if (stalled && pix_valid)
          check("stall_hold", 32'(cw), 32'(prev_w));
        if (pix_valid && pix_ready) begin
          if (q.size() == 0) begin
            check("extra_word", 32'(pix_valid), 0);
          end else begin
            x = q.pop_front();
            check("word", 32'(cw), 32'(x.w));
            check("frame_done", 32'(frame_done), 32'(x.fd));
          end
        end else begin
          check("fd_idle", 32'(frame_done), 0);
        end
        stalled = pix_valid && !pix_ready;
        prev_w = cw;
      end
    end
  end

  initial begin
    int r, reps;
    for (int k = 0; k < NCOL; k++) sh[k] = '0;
    repeat (3) tick();
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_row", 32'(pix_row), 0);
    check("rst_col", 32'(pix_col), 0);
    check("rst_plane", 32'(pix_plane), 0);
    check("rst_rgb", 32'({pix_rgb0, pix_rgb1}), 0);
    check("rst_fd", 32'(frame_done), 0);
    check("rst_on", 32'(on_cycles), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_len", 32'(len_err), 0);
    rst = 1'b0;
    tick();

    // single row on row 5
    shift_row(NCOL, 0);
    do_latch(5'd5);
    wait_drain(0);
    check_flags("row5");

    // oe low 37 cycles between latches
    oe_low(37);
    shift_row(NCOL, 1);
    do_latch(5'd5);
    wait_drain(0);
    check("on37", 32'(on_cycles), 37);
    check_flags("oe");

    // plane counting and frame end
    for (int i = 0; i < 4; i++) begin
      shift_row(NCOL, 1);
      do_latch(5'd23);
      wait_drain(0);
    end
    shift_row(NCOL, 1);
    do_latch(5'd0);
    wait_drain(0);
    check("fd_count", 32'(fd_seen), 32'(fd_exp));
    check_flags("planes");

    // short row
    shift_row(90, 1);
    do_latch(5'd7);
    wait_drain(0);
    check_flags("short");
    pulse_clr();
    check("short_clr", 32'(len_err), 0);

    // backpressure with a second latch while draining
    shift_row(NCOL, 1);
    do_latch(5'd9);
    repeat (40) tick();
    pix_ready = 1'b0;
    repeat (3) tick();
    do_latch(5'd10);
    repeat (2) tick();
    pix_ready = 1'b1;
    wait_drain(0);
    check_flags("bp");
    pulse_clr();
    check("bp_clr", 32'(overrun), 0);

    // loopback-style random rows, planes and backpressure
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, NROW - 1);
      reps = $urandom_range(1, 3);
      for (int j = 0; j < reps; j++) begin
        oe_low($urandom_range(0, 50));
        shift_row(NCOL, 1);
        do_latch(5'(r));
        wait_drain(1);
        check_flags("rand");
      end
    end

    // reset mid-drain aborts the stream
    shift_row(NCOL, 1);
    do_latch(5'd3);
    repeat (20) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    q.delete();
    prev_row = 0;
    plane = 0;
    npulse = 0;
    oe_acc = 0;
    exp_on = 0;
    exp_len = 0;
    exp_ovr = 0;
    tick();
    check("mid_rst_valid", 32'(pix_valid), 0);
    check_flags("mid_rst");

    // row 0 right after reset matches the reset previous row
    shift_row(NCOL, 1);
    do_latch(5'd0);
    wait_drain(0);
    check_flags("post_rst");
    check("fd_final", 32'(fd_seen), 32'(fd_exp));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
